peripheral_noc_packet_arbiter: RTL and testbench
================================================

Name: peripheral_noc_packet_arbiter

Overview:
- Packet-granular round-robin arbiter/multiplexer that shares one flit link among CHANNELS requesters.
- Typical use: several peripheral_noc buffer outputs merge onto one router or network-adapter port.
- Once a channel is granted, it holds the link until its last flit is accepted. Packets are never interleaved.
- Zero-latency pass-through datapath. Sequential state is the lock FSM, the locked grant and the round-robin priority pointer.

Parameters:
- FLIT_WIDTH, 32, width of one flit.
- CHANNELS, 4, number of requesting input channels (>=2).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_flit  input  CHANNELS*FLIT_WIDTH  flits. Channel i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH].
- in_last  input  CHANNELS  last-flit marker per channel.
- in_valid  input  CHANNELS  flit valid per channel.
- in_ready  output  CHANNELS  flit accepted per channel.
- out_flit  output  FLIT_WIDTH  selected flit.
- out_last  output  1  selected last marker.
- out_valid  output  1  selected valid.
- out_ready  input  1  downstream ready.
- grant  output  CHANNELS  one-hot channel currently owning the output; 0 when none.
- busy  output  1  high in state LOCKED.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - Reset values: state=IDLE, locked grant=0, priority pointer=one-hot channel 0.
  - Therefore after reset: busy=0, grant=0 when no in_valid, in_ready=0, out_valid=0, out_flit=0, out_last=0.
- Handshake: a transfer occurs when out_valid & out_ready. For the selected channel g, in_ready[g] = out_ready. All non-selected channels have in_ready=0. Inputs obey valid-hold: once valid, a flit stays until accepted.
- Round-robin pick (combinational): scan from the pointer channel upward with wrap-around. Pick the first channel with in_valid=1, producing a one-hot result. No requests -> pick=0.
- State IDLE:
  - grant = pick.
  - out_* = channel pick, or all zero if pick=0.
  - Transfer with in_last=1 (single-flit packet): stay IDLE. Pointer <= channel after g (CHANNELS-1 wraps to 0).
  - Any request but not a completed single-flit packet (stalled, or non-last flit transferred): -> LOCKED, locked grant <= pick. Latching even when stalled keeps out_flit/out_valid stable under backpressure.
  - No request: stay IDLE, pointer unchanged.
- State LOCKED:
  - grant = locked grant (registered). out_* = that channel. Requests on other channels are ignored.
  - Transfer with in_last=1: -> IDLE, locked grant <= 0, pointer <= channel after g.
  - Otherwise stay LOCKED, including bubbles where in_valid[g]=0.
- Pointer changes only on acceptance of a last flit. This guarantees fairness: every requester is served within CHANNELS-1 packets.
- Simultaneous events:
  - A new request on another channel in the same cycle as a last-flit completion is arbitrated only in the following IDLE cycle. One idle cycle between packets of different channels is mandated.
  - The same channel's next packet also waits for that IDLE cycle.
- Reset mid-packet: state forced to IDLE and pointer to channel 0. The partially sent packet is truncated. Upstream and downstream flush is the system's responsibility.
- Unknown/unused grant encodings cannot occur; the locked grant is always one-hot or 0.

Test Plan (CHANNELS=4, FLIT_WIDTH=32):
- Reset, then all in_valid=0 -> grant=0, busy=0, out_valid=0, in_ready=0000, held for 5 cycles.
- Channel 2 sends 3-flit packet 0xA0,0xA1,0xA2 with out_ready=1 -> output sequence identical on three consecutive cycles. busy=1 after first flit, 0 after 0xA2. Pointer then at channel 3.
- Channels 0,1,3 request 2-flit packets simultaneously from reset -> order ch0, ch1, ch3. No interleaving. One IDLE cycle between packets.
- Ch1 mid-packet with in_valid[1]=0 for 2 cycles while ch0 requests -> grant stays 0010, out_valid=0 during bubble, ch0 in_ready=0.
- out_ready=0 for 4 cycles while ch3 valid in IDLE -> state LOCKED, grant=1000, out_flit stable. A later ch0 request does not preempt.
- rst asserted after 1 of 3 flits on ch1 -> next cycle busy=0, grant=0. A subsequent request from ch0 and ch1 grants ch0 first.

Source files
------------

// File: rtl/peripheral_noc_packet_arbiter.sv
// Packet-granular round-robin arbiter: shares one flit link among CHANNELS
// requesters, holding the grant from first flit until the last flit is accepted.
module peripheral_noc_packet_arbiter #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]            in_last,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]          out_flit,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS-1:0]            grant,
  output logic                           busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [CHANNELS-1:0] ONE = {{(CHANNELS-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [CHANNELS-1:0]   lock_q, lock_d;
  logic [CHANNELS-1:0]   ptr_q, ptr_d;
  logic [CHANNELS-1:0]   req_hi_s, pick_s, sel_s;
  logic [FLIT_WIDTH-1:0] flit_s;
  logic                  xfer_last_s;

  function automatic logic [CHANNELS-1:0] lowest_set(input logic [CHANNELS-1:0] v);
    return v & (~v + ONE);
  endfunction

  function automatic logic [CHANNELS-1:0] rotate_next(input logic [CHANNELS-1:0] g);
    return {g[CHANNELS-2:0], g[CHANNELS-1]};
  endfunction

  // Round-robin pick: prefer requesters at or above the pointer, else wrap to the lowest.
  always_comb begin
    req_hi_s = in_valid & ~(ptr_q - ONE);
    if (|req_hi_s) begin
      pick_s = lowest_set(req_hi_s);
    end else begin
      pick_s = lowest_set(in_valid);
    end
  end

  // Select the owning channel and mux its flit onto the output.
  always_comb begin
    if (state_q == LOCKED) begin
      sel_s = lock_q;
    end else begin
      sel_s = pick_s;
    end
    flit_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel_s[i]) begin
        flit_s = flit_s | in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
      end else begin
        flit_s = flit_s;
      end
    end
  end

  assign out_flit    = flit_s;
  assign out_valid   = |(sel_s & in_valid);
  assign out_last    = |(sel_s & in_last);
  assign in_ready    = sel_s & {CHANNELS{out_ready}};
  assign grant       = sel_s;
  assign busy        = (state_q == LOCKED);
  assign xfer_last_s = out_valid & out_ready & out_last;

  // Lock FSM: the pointer advances only when a last flit is accepted.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|pick_s) begin
          if (xfer_last_s) begin
            ptr_d = rotate_next(pick_s);
          end else begin
            // Latch even when stalled so the output stays stable under backpressure.
            state_d = LOCKED;
            lock_d  = pick_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (xfer_last_s) begin
          state_d = IDLE;
          lock_d  = '0;
          ptr_d   = rotate_next(lock_q);
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = IDLE;
        lock_d  = '0;
        ptr_d   = ONE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
      ptr_q   <= ONE;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_peripheral_noc_packet_arbiter.sv
// Directed testbench for peripheral_noc_packet_arbiter (CHANNELS=4, FLIT_WIDTH=32).
module tb_peripheral_noc_packet_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_flit;
  logic [3:0]   in_last;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [31:0]  out_flit;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   grant;
  logic         busy;
  logic [31:0]  f [4];

  int errors = 0;
  int checks = 0;

  assign in_flit = {f[3], f[2], f[1], f[0]};

  always #5 clk = ~clk;

  peripheral_noc_packet_arbiter #(.FLIT_WIDTH(32), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .grant(grant), .busy(busy)
  );

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 4'b0000; in_last = 4'b0000; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) f[i] = 32'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant c%0d: got %b exp 0000", c, grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy c%0d: got %b exp 0", c, busy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid c%0d: got %b exp 0", c, out_valid); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready c%0d: got %b exp 0000", c, in_ready); end
      checks++; if (out_flit !== 32'h0) begin errors++; $display("FAIL reset_out_flit c%0d: got %h exp 0", c, out_flit); end
      next_cycle();
    end
  endtask

  task automatic test_single_packet();
    logic [31:0] exp_f [3];
    exp_f = '{32'hA0, 32'hA1, 32'hA2};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      in_valid = 4'b0100; f[2] = exp_f[c]; in_last = (c == 2) ? 4'b0100 : 4'b0000;
      #1;
      checks++; if (out_flit !== exp_f[c]) begin errors++; $display("FAIL ch2_flit c%0d: got %h exp %h", c, out_flit, exp_f[c]); end
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL ch2_grant c%0d: got %b exp 0100", c, grant); end
      checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL ch2_in_ready c%0d: got %b exp 0100", c, in_ready); end
      checks++; if (busy !== (c != 0)) begin errors++; $display("FAIL ch2_busy c%0d: got %b exp %b", c, busy, c != 0); end
      checks++; if (out_last !== (c == 2)) begin errors++; $display("FAIL ch2_last c%0d: got %b exp %b", c, out_last, c == 2); end
      next_cycle();
    end
    in_valid = 4'b0000; in_last = 4'b0000;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ch2_busy_after: got %b exp 0", busy); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL ch2_grant_after: got %b exp 0000", grant); end
    next_cycle();
    // Pointer now at channel 3: ch3 beats ch0 with single-flit packets.
    in_valid = 4'b1001; in_last = 4'b1001; f[0] = 32'h5; f[3] = 32'h6;
    #1;
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL ptr_ch3_grant: got %b exp 1000", grant); end
    checks++; if (out_flit !== 32'h6) begin errors++; $display("FAIL ptr_ch3_flit: got %h exp 6", out_flit); end
    next_cycle();
    in_valid = 4'b0001;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_flit_idle: got %b exp 0", busy); end
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL ptr_ch0_grant: got %b exp 0001", grant); end
    next_cycle();
    in_valid = 4'b0000; in_last = 4'b0000;
  endtask

  task automatic test_three_way();
    int idx [4];
    logic [3:0]  eg [7];
    logic        eb [7];
    logic        ev [7];
    logic [31:0] ef [7];
    eg = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0000};
    eb = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ef = '{32'h00, 32'h01, 32'h10, 32'h11, 32'h30, 32'h31, 32'h00};
    idx = '{0, 0, 0, 0};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      for (int ch = 0; ch < 4; ch++) begin
        in_valid[ch] = (ch != 2) && (idx[ch] < 2);
        in_last[ch]  = (idx[ch] == 1);
        f[ch]        = 32'(ch * 16 + idx[ch]);
      end
      #1;
      checks++; if (grant !== eg[c]) begin errors++; $display("FAIL rr_grant c%0d: got %b exp %b", c, grant, eg[c]); end
      checks++; if (busy !== eb[c]) begin errors++; $display("FAIL rr_busy c%0d: got %b exp %b", c, busy, eb[c]); end
      checks++; if (out_valid !== ev[c]) begin errors++; $display("FAIL rr_valid c%0d: got %b exp %b", c, out_valid, ev[c]); end
      checks++; if (out_flit !== ef[c]) begin errors++; $display("FAIL rr_flit c%0d: got %h exp %h", c, out_flit, ef[c]); end
      for (int ch = 0; ch < 4; ch++) begin
        if (in_ready[ch] && in_valid[ch]) idx[ch]++;
      end
      next_cycle();
    end
    in_valid = 4'b0000; in_last = 4'b0000;
  endtask

  task automatic test_bubble();
    do_reset();
    in_valid = 4'b0010; f[1] = 32'hB0; in_last = 4'b0000;
    #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL bub_first_grant: got %b exp 0010", grant); end
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      in_valid = 4'b0001; f[0] = 32'hE0;
      #1;
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL bub_grant c%0d: got %b exp 0010", c, grant); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bub_out_valid c%0d: got %b exp 0", c, out_valid); end
      checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL bub_ch0_ready c%0d: got %b exp 0", c, in_ready[0]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bub_busy c%0d: got %b exp 1", c, busy); end
      next_cycle();
    end
    in_valid = 4'b0011; f[1] = 32'hB1;
    #1;
    checks++; if (out_flit !== 32'hB1) begin errors++; $display("FAIL bub_b1: got %h exp b1", out_flit); end
    next_cycle();
    f[1] = 32'hB2; in_last = 4'b0010;
    #1;
    checks++; if (out_flit !== 32'hB2 || out_last !== 1'b1) begin errors++; $display("FAIL bub_b2: got %h/%b exp b2/1", out_flit, out_last); end
    next_cycle();
    in_valid = 4'b0001; in_last = 4'b0001;
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL bub_ch0_after: got %b exp 0001", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bub_idle_after: got %b exp 0", busy); end
    next_cycle();
    in_valid = 4'b0000; in_last = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; in_valid = 4'b1000; f[3] = 32'hC0; in_last = 4'b0000;
    #1;
    checks++; if (grant !== 4'b1000 || busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b/%b exp 1000/0", grant, busy); end
    next_cycle();
    for (int c = 1; c < 4; c++) begin
      if (c >= 2) in_valid = 4'b1001;
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy c%0d: got %b exp 1", c, busy); end
      checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL bp_grant c%0d: got %b exp 1000", c, grant); end
      checks++; if (out_flit !== 32'hC0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_flit c%0d: got %h/%b exp c0/1", c, out_flit, out_valid); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready c%0d: got %b exp 0000", c, in_ready); end
      next_cycle();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL bp_release: got %b exp 1000", in_ready); end
    next_cycle();
    f[3] = 32'hC1; in_last = 4'b1000;
    #1;
    checks++; if (grant !== 4'b1000 || out_flit !== 32'hC1) begin errors++; $display("FAIL bp_c1: got %b/%h exp 1000/c1", grant, out_flit); end
    next_cycle();
    in_valid = 4'b0001; in_last = 4'b0000;
    #1;
    checks++; if (grant !== 4'b0001 || busy !== 1'b0) begin errors++; $display("FAIL bp_ch0_next: got %b/%b exp 0001/0", grant, busy); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 4'b0010; f[1] = 32'hD0; in_last = 4'b0000;
    next_cycle();
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_locked: got %b exp 1", busy); end
    f[1] = 32'hD1; rst = 1'b1;
    next_cycle();
    rst = 1'b0; in_valid = 4'b0000;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b exp 0", busy); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rm_grant: got %b exp 0000", grant); end
    next_cycle();
    in_valid = 4'b0011; f[0] = 32'hF0; f[1] = 32'hD0;
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rm_ch0_first: got %b exp 0001", grant); end
    checks++; if (out_flit !== 32'hF0) begin errors++; $display("FAIL rm_ch0_flit: got %h exp f0", out_flit); end
    next_cycle();
    in_valid = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'b0000; in_last = 4'b0000; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) f[i] = 32'h0;
    test_reset();
    test_single_packet();
    test_three_way();
    test_bubble();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
